// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared ALU for every add,
// shift and final flag-setting pass while busy is high.
module alu_mul_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [15:0]      product,
  output logic             prod_zero,
  output logic             prod_neg,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [4:0]       alu_fun_sel,
  output logic             alu_wf,
  input  logic [15:0]      alu_out,
  input  logic [3:0]       alu_flags
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_ADD   | P <= P + M through the ALU
  // S_SHIFT | M <= M << 1 through the ALU, Q >>= 1
  // S_FLAG  | pass P through the ALU with WF=1, capture product
  // S_DONE  | result valid, Z/N shown from the ALU flag register
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_FLAG,
    S_DONE
  } state_t;

  localparam logic [4:0] FUN_PASS_A = 5'b10000;
  localparam logic [4:0] FUN_ADD    = 5'b10100;
  localparam logic [4:0] FUN_LSL    = 5'b11011;

  state_t           state, state_nxt, start_state;
  logic [15:0]      p, m;
  logic [WIDTH-1:0] q;
  logic [15:0]      product_q;
  logic             zero_q, neg_q;
  logic             accept;
  logic             unused_flags;

  // C and O are irrelevant: the product can never overflow 16 bits.
  assign unused_flags = ^{alu_flags[2], alu_flags[0]};

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    start_state = S_SHIFT;
    if (op_b == '0)
      start_state = S_FLAG;
    else if (op_b[0])
      start_state = S_ADD;

    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    alu_a       = 16'h0000;
    alu_b       = 16'h0000;
    alu_fun_sel = 5'b00000;
    alu_wf      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = start_state;
      end
      S_ADD: begin
        busy        = 1'b1;
        alu_a       = p;
        alu_b       = m;
        alu_fun_sel = FUN_ADD;
        state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        busy        = 1'b1;
        alu_a       = m;
        alu_fun_sel = FUN_LSL;
        if (q[WIDTH-1:1] == '0)
          state_nxt = S_FLAG;
        else if (q[1])
          state_nxt = S_ADD;
        else
          state_nxt = S_SHIFT;
      end
      S_FLAG: begin
        busy        = 1'b1;
        alu_a       = p;
        alu_fun_sel = FUN_PASS_A;
        alu_wf      = 1'b1;
        state_nxt   = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? start_state : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= 16'h0000;
      m         <= 16'h0000;
      q         <= '0;
      product_q <= 16'h0000;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      case (state)
        S_ADD: p <= alu_out;
        S_SHIFT: begin
          m <= alu_out;
          q <= q >> 1;
        end
        S_FLAG: product_q <= p;
        S_DONE: begin
          zero_q <= alu_flags[3];
          neg_q  <= alu_flags[1];
        end
        default: ;
      endcase
      if (accept) begin
        p <= 16'h0000;
        m <= {{(16-WIDTH){1'b0}}, op_a};
        q <= op_b;
      end
    end
  end

  // In DONE the flag register already holds the FLAG-cycle result, so show it live.
  assign product   = product_q;
  assign prod_zero = (state == S_DONE) ? alu_flags[3] : zero_q;
  assign prod_neg  = (state == S_DONE) ? alu_flags[1] : neg_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: a stand-in ALU, a reference multiply
// with the latency rule, and a done-triggered monitor.
module tb_alu_mul_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             busy, done;
  logic [15:0]      product;
  logic             prod_zero, prod_neg;
  logic [15:0]      alu_a, alu_b;
  logic [4:0]       alu_fun_sel;
  logic             alu_wf;
  logic [15:0]      alu_out;
  logic [3:0]       alu_flags;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wf_cnt   = 0;
  int add_cnt  = 0;
  int bad_b    = 0;

  typedef struct {
    logic [15:0] prod;
    logic        z;
    logic        n;
    int          lat;
    int          adds;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];

  alu_mul_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .prod_zero  (prod_zero),
    .prod_neg   (prod_neg),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fun_sel(alu_fun_sel),
    .alu_wf     (alu_wf),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Stand-in for the shared ALU: only the three functions the sequencer uses.
  always_comb begin
    alu_out = 16'h0000;
    case (alu_fun_sel)
      5'b10000: alu_out = alu_a;
      5'b10100: alu_out = alu_a + alu_b;
      5'b11011: alu_out = alu_a << 1;
      default:  alu_out = 16'h0000;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_flags <= 4'h0;
    else if (alu_wf) alu_flags <= {alu_out == 16'h0000, 1'b0, alu_out[15], 1'b0};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int sc);
    exp_t e;
    int pc, msb;
    pc  = 0;
    msb = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) begin
        pc++;
        msb = i;
      end
    end
    e.prod      = 16'(a * b);
    e.z         = (a * b) == 0;
    e.n         = e.prod[15];
    e.lat       = pc + (msb + 1) + 2;
    e.adds      = pc;
    e.start_cyc = sc;
    return e;
  endfunction

  // Monitor: per-cycle ALU usage bookkeeping, full compare whenever done is seen.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_wf) wf_cnt++;
      if (alu_fun_sel == 5'b10100) add_cnt++;
      if (alu_fun_sel != 5'b10100 && alu_b != 16'h0000) bad_b++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("product",   32'(product),   32'(e.prod));
          check("prod_zero", 32'(prod_zero), 32'(e.z));
          check("prod_neg",  32'(prod_neg),  32'(e.n));
          check("latency",   32'(cyc - e.start_cyc), 32'(e.lat));
          check("add_cycles", 32'(add_cnt), 32'(e.adds));
          check("wf_cycles", 32'(wf_cnt), 32'd1);
          check("alu_b_idle_zero", 32'(bad_b), 32'd0);
        end
        wf_cnt  = 0;
        add_cnt = 0;
        bad_b   = 0;
      end
    end
  end

  task automatic issue(input int a, input int b);
    op_a  = WIDTH'(a);
    op_b  = WIDTH'(b);
    start = 1'b1;
    exp_q.push_back(model(a, b, cyc));
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 64 && !done; i++) @(negedge clk);
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic run_op(input int a, input int b);
    exp_t e;
    e = model(a, b, 0);
    @(negedge clk);
    issue(a, b);
    @(negedge clk);
    start = 1'b0;
    op_a  = WIDTH'($urandom);
    op_b  = WIDTH'($urandom);
    wait_done("run_op");
    @(negedge clk);
    check("held_product", 32'(product), 32'(e.prod));
    check("held_zero", 32'(prod_zero), 32'(e.z));
    check("held_neg",  32'(prod_neg),  32'(e.n));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},    32'(busy), 32'd0);
    check({name, "_done"},    32'(done), 32'd0);
    check({name, "_product"}, 32'(product), 32'd0);
    check({name, "_zero"},    32'(prod_zero), 32'd0);
    check({name, "_neg"},     32'(prod_neg), 32'd0);
    check({name, "_alu_a"},   32'(alu_a), 32'd0);
    check({name, "_alu_b"},   32'(alu_b), 32'd0);
    check({name, "_fun_sel"}, 32'(alu_fun_sel), 32'd0);
    check({name, "_wf"},      32'(alu_wf), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_op(3, 5);
    run_op(255, 255);
    run_op(7, 0);

    // start held high through busy with new operands: second op launches from DONE
    @(negedge clk);
    issue(2, 2);
    @(negedge clk);
    op_a = WIDTH'(4);
    op_b = WIDTH'(4);
    wait_done("held_first");
    exp_q.push_back(model(4, 4, cyc));
    @(negedge clk);
    start = 1'b0;
    wait_done("held_second");
    @(negedge clk);
    check("b2b_final_product", 32'(product), 32'd16);

    // async reset in the middle of 9x9
    @(negedge clk);
    issue(9, 9);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midop_reset");
    exp_q.delete();
    wf_cnt  = 0;
    add_cnt = 0;
    bad_b   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(9, 9);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(a, b);

    for (int i = 0; i < 200; i++)
      run_op(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
